// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine bridging the core to a ready-handshake data bus
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic to_flag;
  logic op, illegal, mis, start, timeout_hit;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] fmt, be_wdata;
  logic [3:0] be_new;
  assign op = mem_read | mem_write;
  assign illegal = (mem_read & mem_write)
                 | (mem_read & (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                 | (mem_write & (funct3 == 3'b011 || funct3[2]));
  assign mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign start = state == IDLE && op && !illegal && !mis;
  assign timeout_hit = TIMEOUT_CYCLES != 0 && cnt == LAST;
  assign be_new = mem_read ? 4'b1111 : funct3[1] ? 4'b1111 :
                  funct3[0] ? 4'b0011 << addr[1:0] : 4'b0001 << addr[1:0];
  assign be_wdata = mem_read ? 32'd0 : funct3[1] ? store_data :
                    funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  assign rbyte = bus_rdata[8*off_q +: 8];
  assign rhalf = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign fmt = f3_q[1] ? bus_rdata :
               f3_q[0] ? {{16{~f3_q[2] & rhalf[15]}}, rhalf} : {{24{~f3_q[2] & rbyte[7]}}, rbyte};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // next-state: one ACCESS phase, then a single DONE retire cycle
  always_comb
    next_state = state == IDLE   ? (start ? ACCESS : IDLE) :
                 state == ACCESS ? ((bus_ready || timeout_hit) ? DONE : ACCESS) : IDLE;
  // pulse/stall outputs, all held low while reset is asserted
  always_comb begin
    stall = rst_n & (start | state == ACCESS);
    misaligned = rst_n & state == IDLE & op & ~illegal & mis;
    access_err = rst_n & ((state == IDLE & op & illegal) | (state == DONE & to_flag));
  end
  // bus registers, captured instruction fields, timeout counter and load result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      load_data <= '0;
      cnt <= '0;
      f3_q <= '0;
      off_q <= '0;
      to_flag <= 1'b0;
    end else if (start) begin
      bus_req <= 1'b1;
      bus_we <= mem_write;
      bus_addr <= {addr[31:2], 2'b00};
      bus_be <= be_new;
      bus_wdata <= be_wdata;
      f3_q <= funct3;
      off_q <= addr[1:0];
      cnt <= '0;
    end else if (state == ACCESS) begin
      if (bus_ready) begin
        bus_req <= 1'b0;
        if (!bus_we) load_data <= fmt;
      end else if (timeout_hit) begin
        bus_req <= 1'b0;
        load_data <= '0;
        to_flag <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end else if (state == DONE) to_flag <= 1'b0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized check of load_store_unit against a transaction-level model
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, mem_read = 0, mem_write = 0, bus_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic stall, misaligned, access_err, bus_req, bus_we;
  logic [3:0] bus_be;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_ld = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 0; mem_write = 0; bus_ready = 0;
    funct3 = 3'($urandom); addr = $urandom;
    #1;
    chk("nop_stall", {31'd0, stall}, 0);
    chk("nop_mis", {31'd0, misaligned}, 0);
    chk("nop_err", {31'd0, access_err}, 0);
    @(posedge clk);
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rdat, input int wait_n);
    bit ill, mis, go, tmo;
    int size, o, n;
    logic [3:0] be;
    logic [31:0] wd, v;
    ill = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && (f3 == 3 || f3 >= 4));
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    o = int'(a[1:0]);
    mis = !ill && (rd || wr) && (o % size != 0);
    go = (rd || wr) && !ill && !mis;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; bus_ready = 0;
    #1;
    chk("idle_stall", {31'd0, stall}, {31'd0, go});
    chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
    chk("access_err", {31'd0, access_err}, {31'd0, (rd || wr) && ill});
    chk("idle_req", {31'd0, bus_req}, 0);
    chk("idle_ld", load_data, exp_ld);
    if (!go) begin
      @(posedge clk);
      #1 chk("no_req", {31'd0, bus_req}, 0);
      return;
    end
    be = 0; wd = 0;
    if (rd) be = 4'hf;
    else for (int i = 0; i < 4; i++) begin
      if (i >= o && i < o + size) be[i] = 1'b1;
      wd[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    n = 0; tmo = 0;
    forever begin
      n++;
      @(negedge clk);
      bus_ready = (n == wait_n + 1);
      bus_rdata = bus_ready ? rdat : $urandom;
      #1;
      chk("acc_stall", {31'd0, stall}, 1);
      chk("acc_req", {31'd0, bus_req}, 1);
      chk("acc_we", {31'd0, bus_we}, {31'd0, wr});
      chk("acc_addr", bus_addr, {a[31:2], 2'b00});
      chk("acc_be", {28'd0, bus_be}, {28'd0, be});
      chk("acc_wdata", bus_wdata, wd);
      chk("acc_err", {31'd0, access_err}, 0);
      @(posedge clk);
      if (bus_ready) break;
      if (n == TO) begin tmo = 1; break; end
    end
    @(negedge clk);
    bus_ready = 0;
    if (tmo) exp_ld = 0;
    else if (rd) begin
      if (size == 1) begin
        v = (rdat >> (8 * o)) & 32'hff;
        if (!f3[2] && v[7]) v = v | 32'hffffff00;
      end else if (size == 2) begin
        v = (rdat >> (16 * (o / 2))) & 32'hffff;
        if (!f3[2] && v[15]) v = v | 32'hffff0000;
      end else v = rdat;
      exp_ld = v;
    end
    #1;
    chk("done_stall", {31'd0, stall}, 0);
    chk("done_err", {31'd0, access_err}, {31'd0, tmo});
    chk("done_req", {31'd0, bus_req}, 0);
    chk("done_ld", load_data, exp_ld);
    @(posedge clk);
  endtask

  initial begin
    mem_read = 1; mem_write = 1; funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_err", {31'd0, access_err}, 0);
    chk("rst_req", {31'd0, bus_req}, 0);
    chk("rst_be", {28'd0, bus_be}, 0);
    chk("rst_ld", load_data, 0);
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    rst_n = 1;
    txn(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lb_val", load_data, 32'hFFFF_FF80);
    txn(1, 0, 3'b100, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lbu_val", load_data, 32'h0000_0080);
    txn(0, 1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 0, 3);
    chk("sh_ld_kept", load_data, 32'h0000_0080);
    txn(1, 0, 3'b010, 32'h0006, 0, 0, 0);
    txn(1, 0, 3'b001, 32'h0006, 0, 32'h7FFF_0000, 0);
    chk("lh_val", load_data, 32'h0000_7FFF);
    txn(1, 0, 3'b010, 32'h0040, 0, 32'h1234_5678, 9);
    chk("to_ld", load_data, 0);
    txn(1, 1, 3'b010, 32'h0000, 0, 0, 0);
    txn(1, 0, 3'b110, 32'h0000, 0, 0, 0);
    txn(1, 0, 3'b101, 32'h0102, 0, 32'h8001_0000, 1);
    idle_cycle();
    for (int k = 0; k < 250; k++) begin
      bit r, w;
      r = 1'($urandom); w = ($urandom_range(0, 7) == 0) ? 1'b1 : ~r;
      if ($urandom_range(0, 9) == 0) idle_cycle();
      txn(r, w, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end
    txn(1, 0, 3'b010, 32'h0000_0100, 0, 32'hCAFE_F00D, 0);
    @(negedge clk);
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h200; bus_ready = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_req", {31'd0, bus_req}, 0);
    chk("arst_stall", {31'd0, stall}, 0);
    chk("arst_be", {28'd0, bus_be}, 0);
    chk("arst_ld", load_data, 0);
    exp_ld = 0;
    mem_read = 0;
    @(negedge clk);
    rst_n = 1;
    txn(0, 1, 3'b010, 32'h0000_0300, 32'h0BAD_CAFE, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
